// File: rtl/otsu_binarize_ctrl_pkg.sv
// otsu_binarize_ctrl_pkg
// Shared image-processing definitions for the Otsu binarization controller:
// FSM state encoding, default threshold, timing constants and a saturating
// increment helper. No ports.
package otsu_binarize_ctrl_pkg;

    typedef logic [7:0] pix_t;

    typedef enum logic [2:0] {
        ARM    = 3'd0,
        HIST   = 3'd1,
        SETTLE = 3'd2,
        CALC   = 3'd3,
        LATCH  = 3'd4,
        HOLD   = 3'd5
    } state_t;

    localparam pix_t        DEFAULT_THR_C    = 8'd128;
    localparam logic [7:0]  REFRESH_FRAMES_C = 8'd1;
    localparam logic [15:0] CALC_TIMEOUT_C   = 16'd65535;
    localparam logic [8:0]  HOLDOFF_CYCLES_C = 9'd260;
    localparam logic [1:0]  SETTLE_CYCLES    = 2'd2;

    // Frame counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/otsu_binarize_ctrl_if.sv
// otsu_binarize_ctrl_if
// Link between the binarization controller and the Otsu histogram/threshold
// engine.
//   img_y                 : registered grey level fed to the histogram
//   data_stare            : histogram-count enable
//   data_end              : threshold-compute enable
//   threshold_finish_flag : Otsu done level
//   otsu_k_value          : Otsu threshold, valid while the flag is high
// master = controller side, slave = Otsu engine side.
interface otsu_binarize_ctrl_if;
    import otsu_binarize_ctrl_pkg::*;

    pix_t img_y;
    logic data_stare;
    logic data_end;
    logic threshold_finish_flag;
    pix_t otsu_k_value;

    modport master (
        output img_y,
        output data_stare,
        output data_end,
        input  threshold_finish_flag,
        input  otsu_k_value
    );

    modport slave (
        input  img_y,
        input  data_stare,
        input  data_end,
        output threshold_finish_flag,
        output otsu_k_value
    );

endinterface

// File: rtl/otsu_edge_det.sv
// otsu_edge_det
// Rising-edge detector for a level signal.
//   clk  : clock
//   rst  : synchronous active-high reset
//   din  : level input
//   rise : high in the cycle where din is 1 and was 0 on the previous cycle
module otsu_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/otsu_binarize_ctrl.sv
// otsu_binarize_ctrl
// Schedules the Otsu engine (histogram frame, settle, compute, latch,
// hold-off) and binarizes the pixel stream with the active threshold.
//   clk, rst                   : clock, synchronous active-high reset
//   pix_valid/pix_y            : input pixel stream
//   pix_sof/pix_eof            : frame markers, qualified by pix_valid
//   otsu (master)              : img_y, data_stare, data_end out;
//                                threshold_finish_flag, otsu_k_value in
//   bin_valid/bin_pix          : binarized pixel, 1-cycle latency
//   bin_sof/bin_eof            : delayed frame markers
//   thr_active                 : threshold applied to the current frame
//   thr_update                 : one-cycle pulse when thr_active changes
//   calc_timeout_err           : sticky compute-timeout flag
module otsu_binarize_ctrl
    import otsu_binarize_ctrl_pkg::*;
#(
    parameter pix_t        DEFAULT_THR    = DEFAULT_THR_C,
    parameter logic [7:0]  REFRESH_FRAMES = REFRESH_FRAMES_C,
    parameter logic [15:0] CALC_TIMEOUT   = CALC_TIMEOUT_C,
    parameter logic [8:0]  HOLDOFF_CYCLES = HOLDOFF_CYCLES_C
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pix_valid,
    input  pix_t                        pix_y,
    input  logic                        pix_sof,
    input  logic                        pix_eof,
    otsu_binarize_ctrl_if.master        otsu,
    output logic                        bin_valid,
    output logic                        bin_pix,
    output logic                        bin_sof,
    output logic                        bin_eof,
    output pix_t                        thr_active,
    output logic                        thr_update,
    output logic                        calc_timeout_err
);

    state_t      state;
    logic [7:0]  frame_cnt;
    pix_t        thr_pending;
    logic [15:0] calc_cnt;
    logic [8:0]  hold_cnt;
    logic [1:0]  settle_cnt;
    logic        flag_rise;
    logic        sof_v;
    logic        eof_v;
    logic        refresh_due;
    logic        bin_armed;
    pix_t        thr_next;

    assign sof_v       = pix_valid & pix_sof;
    assign eof_v       = pix_valid & pix_eof;
    assign refresh_due = (frame_cnt >= REFRESH_FRAMES);

    // The sof pixel must already be compared against the threshold that is
    // being loaded for its frame, otherwise frame pixel 0 would use the old one.
    assign thr_next = sof_v ? thr_pending : thr_active;

    otsu_edge_det u_flag_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (otsu.threshold_finish_flag),
        .rise (flag_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ARM;
            frame_cnt        <= REFRESH_FRAMES;
            thr_pending      <= DEFAULT_THR;
            calc_cnt         <= '0;
            hold_cnt         <= '0;
            settle_cnt       <= '0;
            calc_timeout_err <= 1'b0;
            otsu.data_stare  <= 1'b0;
            otsu.data_end    <= 1'b0;
            otsu.img_y       <= '0;
        end else begin
            otsu.data_stare <= 1'b0;
            if (eof_v && (state != HIST)) begin
                frame_cnt <= sat_inc8(frame_cnt);
            end

            case (state)
                ARM: begin
                    if (sof_v && refresh_due) begin
                        otsu.data_stare <= 1'b1;
                        otsu.img_y      <= pix_y;
                        // A 1-pixel histogram frame is not a binarized completion.
                        frame_cnt       <= frame_cnt;
                        if (pix_eof) begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
                        end else begin
                            state <= HIST;
                        end
                    end
                end

                HIST: begin
                    if (pix_valid) begin
                        // A sof here means the eof was lost: close the histogram
                        // without counting the new frame's first pixel.
                        if (pix_sof) begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
                        end else begin
                            otsu.data_stare <= 1'b1;
                            otsu.img_y      <= pix_y;
                            if (pix_eof) begin
                                state      <= SETTLE;
                                settle_cnt <= '0;
                            end
                        end
                    end
                end

                SETTLE: begin
                    if (settle_cnt == SETTLE_CYCLES - 2'd1) begin
                        state         <= CALC;
                        calc_cnt      <= '0;
                        otsu.data_end <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end
                end

                CALC: begin
                    if (flag_rise) begin
                        thr_pending   <= otsu.otsu_k_value;
                        state         <= LATCH;
                        otsu.data_end <= 1'b0;
                    end else if (calc_cnt == CALC_TIMEOUT - 16'd1) begin
                        calc_timeout_err <= 1'b1;
                        state            <= LATCH;
                        otsu.data_end    <= 1'b0;
                    end else begin
                        calc_cnt <= calc_cnt + 16'd1;
                    end
                end

                LATCH: begin
                    state    <= HOLD;
                    hold_cnt <= '0;
                end

                HOLD: begin
                    if (hold_cnt == HOLDOFF_CYCLES - 9'd1) begin
                        state     <= ARM;
                        frame_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 9'd1;
                    end
                end

                default: begin
                    state <= ARM;
                end
            endcase
        end
    end

    // Binarize path runs in every FSM state. After reset, output is held off
    // until a sof so a partially seen frame is never emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_active <= DEFAULT_THR;
            thr_update <= 1'b0;
            bin_armed  <= 1'b0;
            bin_valid  <= 1'b0;
            bin_pix    <= 1'b0;
            bin_sof    <= 1'b0;
            bin_eof    <= 1'b0;
        end else begin
            thr_update <= sof_v && (thr_pending != thr_active);
            if (sof_v) begin
                thr_active <= thr_pending;
                bin_armed  <= 1'b1;
            end
            bin_valid <= pix_valid && (bin_armed || pix_sof);
            bin_sof   <= sof_v;
            bin_eof   <= eof_v && (bin_armed || pix_sof);
            bin_pix   <= pix_valid && (bin_armed || pix_sof) && (pix_y > thr_next);
        end
    end

endmodule

// File: tb/tb_otsu_binarize_ctrl.sv
// tb_otsu_binarize_ctrl
// Directed self-checking bench for otsu_binarize_ctrl with CALC_TIMEOUT=100.
module tb_otsu_binarize_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_valid;
    logic [7:0] pix_y;
    logic       pix_sof;
    logic       pix_eof;
    logic       bin_valid;
    logic       bin_pix;
    logic       bin_sof;
    logic       bin_eof;
    logic [7:0] thr_active;
    logic       thr_update;
    logic       calc_timeout_err;

    int checks     = 0;
    int failures   = 0;
    int stareCount = 0;
    int updCount   = 0;
    int calcCycles = 0;

    otsu_binarize_ctrl_if otsu_if ();

    otsu_binarize_ctrl #(
        .CALC_TIMEOUT (16'd100)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pix_valid        (pix_valid),
        .pix_y            (pix_y),
        .pix_sof          (pix_sof),
        .pix_eof          (pix_eof),
        .otsu             (otsu_if),
        .bin_valid        (bin_valid),
        .bin_pix          (bin_pix),
        .bin_sof          (bin_sof),
        .bin_eof          (bin_eof),
        .thr_active       (thr_active),
        .thr_update       (thr_update),
        .calc_timeout_err (calc_timeout_err)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expected value and tally the result.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of pixel inputs, then sample just after the clock edge.
    task automatic applyStimulus(input logic v, input logic s, input logic e, input logic [7:0] y);
        pix_valid = v;
        pix_sof   = s;
        pix_eof   = e;
        pix_y     = y;
        @(posedge clk);
        #1;
        if (otsu_if.data_stare) stareCount++;
        if (thr_update) updCount++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        end
    endtask

    // Send an n-pixel frame alternating ya/yb and check every binarized pixel
    // against the threshold the bench expects for that frame.
    task automatic sendFrame(input int n, input logic [7:0] ya, input logic [7:0] yb,
                             input logic [7:0] expThr, input string tag);
        for (int i = 0; i < n; i++) begin
            logic [7:0] y;
            y = (i % 2 == 0) ? ya : yb;
            applyStimulus(1'b1, i == 0, i == n - 1, y);
            checkOutput({tag, "_bin_valid"}, 32'(bin_valid), 32'd1);
            checkOutput({tag, "_bin_pix"}, 32'(bin_pix), 32'(y > expThr));
            checkOutput({tag, "_bin_sof"}, 32'(bin_sof), 32'(i == 0));
            checkOutput({tag, "_bin_eof"}, 32'(bin_eof), 32'(i == n - 1));
            checkOutput({tag, "_thr_active"}, 32'(thr_active), 32'(expThr));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_eof   = 1'b0;
        pix_y     = 8'd0;
        otsu_if.threshold_finish_flag = 1'b0;
        otsu_if.otsu_k_value          = 8'd0;
        idle(3);

        $display("[TB] reset state");
        checkOutput("rst_data_stare", 32'(otsu_if.data_stare), 32'd0);
        checkOutput("rst_data_end", 32'(otsu_if.data_end), 32'd0);
        checkOutput("rst_img_y", 32'(otsu_if.img_y), 32'd0);
        checkOutput("rst_thr_active", 32'(thr_active), 32'd128);
        checkOutput("rst_thr_update", 32'(thr_update), 32'd0);
        checkOutput("rst_bin_valid", 32'(bin_valid), 32'd0);
        checkOutput("rst_timeout_err", 32'(calc_timeout_err), 32'd0);
        rst = 1'b0;

        $display("[TB] 4x4 histogram frame at default threshold");
        stareCount = 0;
        updCount   = 0;
        sendFrame(16, 8'd20, 8'd200, 8'd128, "t1");
        checkOutput("t1_stare_cycles", 32'(stareCount), 32'd16);
        checkOutput("t1_img_y_last", 32'(otsu_if.img_y), 32'd200);
        checkOutput("t1_no_update", 32'(updCount), 32'd0);
        idle(1);
        checkOutput("t1_settle_stare", 32'(otsu_if.data_stare), 32'd0);
        checkOutput("t1_settle_end", 32'(otsu_if.data_end), 32'd0);
        idle(1);
        checkOutput("t1_calc_end", 32'(otsu_if.data_end), 32'd1);

        $display("[TB] accept k=90 on flag rise");
        otsu_if.otsu_k_value          = 8'd90;
        otsu_if.threshold_finish_flag = 1'b1;
        idle(1);
        checkOutput("t2_accept_end", 32'(otsu_if.data_end), 32'd0);
        checkOutput("t2_thr_not_yet", 32'(thr_active), 32'd128);
        otsu_if.threshold_finish_flag = 1'b0;
        idle(270);
        updCount = 0;
        sendFrame(4, 8'd90, 8'd91, 8'd90, "t2");
        checkOutput("t2_update_pulses", 32'(updCount), 32'd1);
        checkOutput("t2_no_hist", 32'(stareCount), 32'd16);

        $display("[TB] flag high at CALC entry is ignored");
        otsu_if.otsu_k_value          = 8'd77;
        otsu_if.threshold_finish_flag = 1'b1;
        sendFrame(4, 8'd100, 8'd50, 8'd90, "t3");
        checkOutput("t3_stare_cycles", 32'(stareCount), 32'd20);
        idle(2);
        checkOutput("t3_calc_entry", 32'(otsu_if.data_end), 32'd1);
        idle(5);
        checkOutput("t3_held_ignored", 32'(otsu_if.data_end), 32'd1);
        otsu_if.threshold_finish_flag = 1'b0;
        idle(1);
        checkOutput("t3_low_still_calc", 32'(otsu_if.data_end), 32'd1);
        otsu_if.otsu_k_value          = 8'd55;
        otsu_if.threshold_finish_flag = 1'b1;
        idle(1);
        checkOutput("t3_second_rise", 32'(otsu_if.data_end), 32'd0);
        otsu_if.threshold_finish_flag = 1'b0;
        idle(270);
        updCount = 0;
        sendFrame(4, 8'd55, 8'd56, 8'd55, "t3b");
        checkOutput("t3_update_pulses", 32'(updCount), 32'd1);

        $display("[TB] sof arriving mid-histogram");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd10);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd10);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd10);
        checkOutput("t4_partial_stare", 32'(stareCount), 32'd23);
        sendFrame(4, 8'd30, 8'd60, 8'd55, "t4");
        checkOutput("t4_new_frame_no_stare", 32'(stareCount), 32'd23);
        checkOutput("t4_img_y_held", 32'(otsu_if.img_y), 32'd10);
        checkOutput("t4_in_calc", 32'(otsu_if.data_end), 32'd1);

        $display("[TB] reset in CALC");
        rst = 1'b1;
        idle(1);
        checkOutput("t5_end_dropped", 32'(otsu_if.data_end), 32'd0);
        checkOutput("t5_thr_default", 32'(thr_active), 32'd128);
        checkOutput("t5_timeout_err", 32'(calc_timeout_err), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd200);
        checkOutput("t5_orphan_valid", 32'(bin_valid), 32'd0);
        checkOutput("t5_orphan_pix", 32'(bin_pix), 32'd0);
        checkOutput("t5_orphan_stare", 32'(otsu_if.data_stare), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd200);
        checkOutput("t5_orphan_eof", 32'(bin_eof), 32'd0);

        $display("[TB] CALC timeout");
        updCount = 0;
        sendFrame(4, 8'd20, 8'd200, 8'd128, "t6");
        checkOutput("t6_stare_cycles", 32'(stareCount), 32'd27);
        idle(2);
        checkOutput("t6_err_clear_at_entry", 32'(calc_timeout_err), 32'd0);
        calcCycles = otsu_if.data_end ? 1 : 0;
        for (int g = 0; g < 300 && otsu_if.data_end; g++) begin
            idle(1);
            if (otsu_if.data_end) calcCycles++;
        end
        checkOutput("t6_calc_cycles", 32'(calcCycles), 32'd100);
        checkOutput("t6_timeout_err", 32'(calc_timeout_err), 32'd1);
        checkOutput("t6_thr_unchanged", 32'(thr_active), 32'd128);
        idle(270);
        sendFrame(4, 8'd128, 8'd129, 8'd128, "t6b");
        checkOutput("t6_binarized_no_hist", 32'(stareCount), 32'd27);
        sendFrame(4, 8'd0, 8'd255, 8'd128, "t6c");
        checkOutput("t6_armed_hist", 32'(stareCount), 32'd31);
        checkOutput("t6_err_sticky", 32'(calc_timeout_err), 32'd1);
        checkOutput("t6_no_update", 32'(updCount), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
